// File: rtl/branch_target_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Lookup is combinational on if_pc; training happens at the clock edge from execute.
module branch_target_predictor #(
    parameter int IDX_BITS = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        ex_valid,
    input  logic [31:0] ex_pc,
    input  logic        ex_is_branch,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    input  logic        ex_predict_wrong,
    output logic [31:0] br_count,
    output logic [31:0] mispred_count
);

    localparam int unsigned ENTRIES = 1 << IDX_BITS;
    localparam int TAG_W = 30 - IDX_BITS;

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];
    logic [1:0]         cnt_q    [ENTRIES];

    logic [IDX_BITS-1:0] if_idx, ex_idx;
    logic [TAG_W-1:0]    if_tag, ex_tag;
    logic                if_hit, ex_hit;
    logic                unused_pc_bits;

    assign if_idx = if_pc[IDX_BITS+1:2];
    assign if_tag = if_pc[31:IDX_BITS+2];
    assign ex_idx = ex_pc[IDX_BITS+1:2];
    assign ex_tag = ex_pc[31:IDX_BITS+2];
    assign unused_pc_bits = ^{if_pc[1:0], ex_pc[1:0]};

    always_comb begin
        if_hit = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
        ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
        pred_taken  = if_hit && cnt_q[if_idx][1];
        pred_target = pred_taken ? target_q[if_idx] : if_pc + 32'd4;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q       <= '0;
            br_count      <= '0;
            mispred_count <= '0;
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                cnt_q[i] <= 2'b01;
            end
        end else if (ex_valid) begin
            if (ex_is_branch) begin
                br_count <= br_count + 32'd1;
            end
            if (ex_predict_wrong) begin
                mispred_count <= mispred_count + 32'd1;
            end
            if (ex_is_branch && ex_hit) begin
                if (ex_taken) begin
                    target_q[ex_idx] <= ex_target;
                    if (cnt_q[ex_idx] != 2'b11) begin
                        cnt_q[ex_idx] <= cnt_q[ex_idx] + 2'd1;
                    end
                end else if (cnt_q[ex_idx] != 2'b00) begin
                    cnt_q[ex_idx] <= cnt_q[ex_idx] - 2'd1;
                end
            end else if (ex_is_branch && ex_taken) begin
                // Miss on a taken branch evicts whatever occupies the slot.
                valid_q[ex_idx]  <= 1'b1;
                tag_q[ex_idx]    <= ex_tag;
                target_q[ex_idx] <= ex_target;
                cnt_q[ex_idx]    <= 2'b10;
            end else if (!ex_is_branch && ex_hit) begin
                valid_q[ex_idx] <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed bench for branch_target_predictor: expectations are queued when a
// step is driven and popped when the combinational outputs are sampled.
module tb_branch_target_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic        ex_is_branch;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        ex_predict_wrong;
    logic [31:0] br_count;
    logic [31:0] mispred_count;

    int vectors = 0;
    int miscompares = 0;
    int step_no = 0;

    typedef struct {
        int          step;
        logic        pt;
        logic [31:0] tgt;
        logic [31:0] bc;
        logic [31:0] mc;
    } exp_t;

    exp_t sb[$];

    branch_target_predictor #(.IDX_BITS(6)) dut (
        .clk             (clk),
        .rst             (rst),
        .if_pc           (if_pc),
        .pred_taken      (pred_taken),
        .pred_target     (pred_target),
        .ex_valid        (ex_valid),
        .ex_pc           (ex_pc),
        .ex_is_branch    (ex_is_branch),
        .ex_taken        (ex_taken),
        .ex_target       (ex_target),
        .ex_predict_wrong(ex_predict_wrong),
        .br_count        (br_count),
        .mispred_count   (mispred_count)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string name, input int step, input logic [31:0] obs,
                       input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s step %0d: observed %h expected %h", name, step, obs, expv);
        end
    endtask

    // Drive one cycle's inputs (just after a falling edge), queue the expected
    // pre-edge outputs, sample them, then advance to the next falling edge.
    task automatic step(input logic r, input logic [31:0] ipc,
                        input logic v, input logic [31:0] epc, input logic br,
                        input logic tk, input logic [31:0] tgt, input logic pw,
                        input logic e_pt, input logic [31:0] e_tgt,
                        input logic [31:0] e_bc, input logic [31:0] e_mc);
        exp_t e;
        rst = r; if_pc = ipc;
        ex_valid = v; ex_pc = epc; ex_is_branch = br; ex_taken = tk;
        ex_target = tgt; ex_predict_wrong = pw;
        step_no++;
        sb.push_back('{step_no, e_pt, e_tgt, e_bc, e_mc});
        #2;
        e = sb.pop_front();
        cmp("pred_taken", e.step, {31'd0, pred_taken}, {31'd0, e.pt});
        cmp("pred_target", e.step, pred_target, e.tgt);
        cmp("br_count", e.step, br_count, e.bc);
        cmp("mispred_count", e.step, mispred_count, e.mc);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; if_pc = 32'h100; ex_valid = 1'b0; ex_pc = '0;
        ex_is_branch = 1'b0; ex_taken = 1'b0; ex_target = '0; ex_predict_wrong = 1'b0;
        @(negedge clk);
        //   rst ifpc          v  expc          br tk tgt           pw  ept  etgt          ebc           emc
        // reset state; same-cycle allocate at 0x100 is not visible yet
        step(0, 32'h100,       1, 32'h100,      1, 1, 32'h40,       1,  0, 32'h104,      32'd0,        32'd0);
        step(0, 32'h100,       1, 32'h100,      1, 0, 32'h0,        1,  1, 32'h40,       32'd1,        32'd1);
        step(0, 32'h100,       1, 32'h100,      1, 0, 32'h0,        0,  0, 32'h104,      32'd2,        32'd2);
        step(0, 32'h100,       1, 32'h100,      1, 1, 32'h40,       1,  0, 32'h104,      32'd3,        32'd2);
        step(0, 32'h100,       1, 32'h100,      1, 1, 32'h40,       1,  0, 32'h104,      32'd4,        32'd3);
        step(0, 32'h100,       1, 32'h100,      1, 1, 32'h48,       0,  1, 32'h40,       32'd5,        32'd4);
        step(0, 32'h100,       1, 32'h100,      1, 1, 32'h48,       0,  1, 32'h48,       32'd6,        32'd4);
        // cnt saturated at 3, so one not-taken still predicts taken afterwards
        step(0, 32'h100,       1, 32'h100,      1, 0, 32'h0,        1,  1, 32'h48,       32'd7,        32'd4);
        step(0, 32'h100,       0, 32'h100,      1, 0, 32'h0,        1,  1, 32'h48,       32'd8,        32'd5);
        // 0x200 aliases index 0 with a different tag
        step(0, 32'h100,       1, 32'h200,      1, 1, 32'h80,       1,  1, 32'h48,       32'd8,        32'd5);
        step(0, 32'h100,       0, 32'h0,        0, 0, 32'h0,        0,  0, 32'h104,      32'd9,        32'd6);
        step(0, 32'h200,       1, 32'h200,      0, 0, 32'h0,        1,  1, 32'h80,       32'd9,        32'd6);
        step(0, 32'h200,       1, 32'h300,      0, 0, 32'h0,        0,  0, 32'h204,      32'd9,        32'd7);
        step(0, 32'h104,       1, 32'h104,      1, 0, 32'h0,        0,  0, 32'h108,      32'd9,        32'd7);
        step(0, 32'h104,       1, 32'h104,      1, 1, 32'h10,       1,  0, 32'h108,      32'd10,       32'd7);
        // reset raised during updates wins over them
        step(1, 32'h104,       1, 32'h200,      1, 1, 32'h20,       1,  1, 32'h10,       32'd11,       32'd8);
        step(1, 32'h104,       1, 32'h300,      1, 1, 32'h20,       1,  0, 32'h108,      32'd0,        32'd0);
        step(0, 32'h200,       0, 32'h0,        0, 0, 32'h0,        0,  0, 32'h204,      32'd0,        32'd0);
        step(0, 32'hFFFF_FFFC, 0, 32'h0,        0, 0, 32'h0,        0,  0, 32'h0,        32'd0,        32'd0);
        force dut.br_count = 32'hFFFF_FFFF;
        #1;
        release dut.br_count;
        step(0, 32'h100,       1, 32'h100,      1, 1, 32'h40,       0,  0, 32'h104,      32'hFFFF_FFFF, 32'd0);
        // low PC bits are ignored by the lookup
        step(0, 32'h102,       0, 32'h0,        0, 0, 32'h0,        0,  1, 32'h40,       32'd0,        32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
